// File: rtl/bcd_digit_source.sv
// BCD digit stream source: emits a run of 0..9 digits counting up or down
// under valid/ready flow control, with optional wrap and a stop request.
module bcd_digit_source #(
    parameter bit WRAP = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       start,
    input  logic       dir,
    input  logic       stop,
    input  logic       o_ready,
    output logic [3:0] o_digit,
    output logic       o_valid,
    output logic       o_last,
    output logic       done,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state, state_nx;
    logic [3:0] digit_q, digit_nx;
    logic       dir_q, dir_nx;
    logic       stop_pend, stop_pend_nx;
    logic       last_q, last_nx;
    logic       err_q, err_nx;
    logic       load_ok, load_bad;
    logic [3:0] start_digit;
    logic [3:0] adv_digit;

    function automatic logic [3:0] advance(input logic [3:0] d, input logic down);
        if (down)
            return (d == 4'd0) ? 4'd9 : d - 4'd1;
        else
            return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    // Terminal digit only ends a run when wrapping is disabled.
    function automatic logic is_terminal(input logic [3:0] d, input logic down);
        return !WRAP && (d == (down ? 4'd0 : 4'd9));
    endfunction

    assign load_ok     = load && (load_val <= 4'd9);
    assign load_bad    = load && (load_val > 4'd9);
    assign start_digit = load_ok ? load_val : digit_q;
    assign adv_digit   = advance(digit_q, dir_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            digit_q   <= 4'd0;
            dir_q     <= 1'b0;
            stop_pend <= 1'b0;
            last_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nx;
            digit_q   <= digit_nx;
            dir_q     <= dir_nx;
            stop_pend <= stop_pend_nx;
            last_q    <= last_nx;
            err_q     <= err_nx;
        end
    end

    // o_last is recomputed only when a new beat is presented, so a stop that
    // arrives while a beat is stalled marks the following beat, not this one.
    always_comb begin
        state_nx     = state;
        digit_nx     = digit_q;
        dir_nx       = dir_q;
        stop_pend_nx = stop_pend;
        last_nx      = last_q;
        err_nx       = err_q;
        case (state)
            IDLE: begin
                if (load_ok) begin
                    digit_nx = load_val;
                    err_nx   = 1'b0;
                end else if (load_bad) begin
                    err_nx = 1'b1;
                end
                if (start && !load_bad) begin
                    state_nx     = RUN;
                    dir_nx       = dir;
                    stop_pend_nx = 1'b0;
                    last_nx      = is_terminal(start_digit, dir);
                end
            end
            RUN: begin
                stop_pend_nx = stop_pend | stop;
                if (o_ready) begin
                    if (last_q) begin
                        state_nx = DONE;
                        last_nx  = 1'b0;
                    end else begin
                        digit_nx = adv_digit;
                        last_nx  = stop_pend_nx | is_terminal(adv_digit, dir_q);
                    end
                end
            end
            DONE: begin
                state_nx     = IDLE;
                stop_pend_nx = 1'b0;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign o_digit = digit_q;
    assign o_valid = (state == RUN);
    assign o_last  = last_q;
    assign done    = (state == DONE);
    assign busy    = (state != IDLE);
    assign err     = err_q;

endmodule

// File: tb/tb_bcd_digit_source.sv
// Bench for bcd_digit_source: table of runs, directed corner sequences and a
// randomized phase, all checked cycle by cycle against a behavioural model.
module tb_bcd_digit_source;

    logic       clk = 1'b0;
    logic       rst_n, load, start, dir, stop, o_ready;
    logic [3:0] load_val;
    logic [3:0] dg0, dg1;
    logic       v0, v1, l0, l1, dn0, dn1, b0, b1, e0, e1;

    always #5 clk = ~clk;

    bcd_digit_source #(.WRAP(1'b0)) u_w0 (
        .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val),
        .start(start), .dir(dir), .stop(stop), .o_ready(o_ready),
        .o_digit(dg0), .o_valid(v0), .o_last(l0), .done(dn0), .busy(b0), .err(e0)
    );

    bcd_digit_source #(.WRAP(1'b1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val),
        .start(start), .dir(dir), .stop(stop), .o_ready(o_ready),
        .o_digit(dg1), .o_valid(v1), .o_last(l1), .done(dn1), .busy(b1), .err(e1)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model, index = WRAP value. phase: 0 idle, 1 running, 2 done.
    typedef struct {
        int phase;
        int digit;
        int down;
        bit stop_seen;
        bit last;
        bit err;
    } model_t;
    model_t m[2];

    function automatic int next_digit(int d, int down);
        return down ? (d + 9) % 10 : (d + 1) % 10;
    endfunction

    function automatic bit ends_here(int wrap, int d, int down);
        return (wrap == 0) && (d == (down ? 0 : 9));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) m[i] = '{0, 0, 0, 1'b0, 1'b0, 1'b0};
    endtask

    task automatic model_step();
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            if (m[i].phase == 0) begin
                bit bad = load && (int'(load_val) > 9);
                if (load && !bad) begin m[i].digit = int'(load_val); m[i].err = 1'b0; end
                if (bad) m[i].err = 1'b1;
                if (start && !bad) begin
                    m[i].phase     = 1;
                    m[i].down      = int'(dir);
                    m[i].stop_seen = 1'b0;
                    m[i].last      = ends_here(i, m[i].digit, m[i].down);
                end
            end else if (m[i].phase == 1) begin
                bit sp = m[i].stop_seen | stop;
                if (o_ready) begin
                    if (m[i].last) begin
                        m[i].phase = 2;
                        m[i].last  = 1'b0;
                    end else begin
                        m[i].digit = next_digit(m[i].digit, m[i].down);
                        m[i].last  = sp || ends_here(i, m[i].digit, m[i].down);
                    end
                end
                m[i].stop_seen = sp;
            end else begin
                m[i].phase     = 0;
                m[i].stop_seen = 1'b0;
            end
        end
    endtask

    function automatic logic [15:0] expected(int i);
        return 16'({4'(m[i].digit), m[i].phase == 1, m[i].last, m[i].phase == 2,
                    m[i].phase != 0, m[i].err});
    endfunction

    task automatic tick();
        @(negedge clk);
        check("w0_outputs", 16'({dg0, v0, l0, dn0, b0, e0}), expected(0));
        check("w1_outputs", 16'({dg1, v1, l1, dn1, b1, e1}), expected(1));
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset mid-cycle and confirms outputs clear before any edge.
    task automatic do_reset();
        rst_n = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
        o_ready = 1'b0; dir = 1'b0; load_val = 4'd0;
        model_reset();
        #1;
        check("reset_w0", 16'({dg0, v0, l0, dn0, b0, e0}), 16'd0);
        check("reset_w1", 16'({dg1, v1, l1, dn1, b1, e1}), 16'd0);
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit              wrap;
        bit              do_load;
        logic [3:0]      lv;
        bit              down;
        int              stop_beat;
        int              n;
        logic [7:0][3:0] beats;
    } run_t;

    task automatic run_entry(input run_t r, input int idx);
        int              nb = 0;
        bit              got_done = 1'b0;
        logic [7:0][3:0] got_d = '0;
        logic [7:0]      got_l = '0;
        do_reset();
        load = r.do_load; load_val = r.lv; dir = r.down; start = 1'b1; o_ready = 1'b1;
        tick();
        load = 1'b0; start = 1'b0;
        for (int c = 0; c < 20 && !got_done; c++) begin
            if (r.wrap ? dn1 : dn0) begin
                got_done = 1'b1;
            end else begin
                if (r.wrap ? v1 : v0) begin
                    if (nb < 8) begin
                        got_d[nb] = r.wrap ? dg1 : dg0;
                        got_l[nb] = r.wrap ? l1 : l0;
                    end
                    stop = (nb == r.stop_beat);
                    nb++;
                end else begin
                    stop = 1'b0;
                end
                tick();
            end
        end
        stop = 1'b0;
        check($sformatf("run%0d_done", idx), 16'(got_done), 16'd1);
        check($sformatf("run%0d_len", idx), 16'(nb), 16'(r.n));
        for (int k = 0; k < r.n && k < 8; k++) begin
            check($sformatf("run%0d_beat%0d", idx, k), 16'(got_d[k]), 16'(r.beats[k]));
            check($sformatf("run%0d_last%0d", idx, k), 16'(got_l[k]), 16'(k == r.n - 1));
        end
    endtask

    run_t runs[6];

    initial begin
        rst_n = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
        o_ready = 1'b0; dir = 1'b0; load_val = 4'd0;
        model_reset();
        @(posedge clk);
        #1;

        runs[0] = '{1'b0, 1'b1, 4'd7, 1'b0, -1, 3, {16'h0, 16'h0987}};
        runs[1] = '{1'b1, 1'b1, 4'd1, 1'b1,  3, 5, {12'h0, 20'h78901}};
        runs[2] = '{1'b0, 1'b1, 4'd0, 1'b1, -1, 1, {28'h0, 4'h0}};
        runs[3] = '{1'b0, 1'b1, 4'd5, 1'b1,  1, 3, {20'h0, 12'h345}};
        runs[4] = '{1'b1, 1'b0, 4'd0, 1'b0,  1, 3, {20'h0, 12'h210}};
        runs[5] = '{1'b1, 1'b1, 4'd9, 1'b0,  0, 2, {24'h0, 8'h09}};
        for (int i = 0; i < 6; i++) run_entry(runs[i], i);

        // Back-pressure on beat 4.
        do_reset();
        load = 1'b1; load_val = 4'd2; dir = 1'b0; start = 1'b1; o_ready = 1'b1;
        tick();
        load = 1'b0; start = 1'b0;
        for (int c = 0; c < 10 && dg1 != 4'd4; c++) tick();
        check("bp_reach4", 16'(dg1), 16'd4);
        o_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("bp_hold", 16'({v1, dg1}), 16'({1'b1, 4'd4}));
            tick();
        end
        check("bp_still4", 16'({v1, dg1}), 16'({1'b1, 4'd4}));
        o_ready = 1'b1;
        tick();
        check("bp_next5", 16'(dg1), 16'd5);

        // Invalid load blocks the start and leaves the digit alone.
        do_reset();
        load = 1'b1; load_val = 4'd6;
        tick();
        load_val = 4'd12; start = 1'b1;
        tick();
        load = 1'b0; start = 1'b0;
        check("inv_err", 16'(e1), 16'd1);
        check("inv_idle", 16'({b1, v1}), 16'd0);
        check("inv_digit", 16'(dg1), 16'd6);
        tick();
        check("inv_still_idle", 16'(b1), 16'd0);
        load = 1'b1; load_val = 4'd3;
        tick();
        load = 1'b0;
        check("fix_err", 16'(e1), 16'd0);
        check("fix_digit", 16'(dg1), 16'd3);

        // Reset mid-run, then restart from digit 0.
        do_reset();
        load = 1'b1; load_val = 4'd5; start = 1'b1; o_ready = 1'b1;
        tick();
        load = 1'b0; start = 1'b0;
        tick();
        check("mid_valid", 16'(v1), 16'd1);
        do_reset();
        start = 1'b1; o_ready = 1'b1;
        tick();
        start = 1'b0;
        check("restart_beat0", 16'({v1, dg1}), 16'({1'b1, 4'd0}));

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            load     = ($urandom_range(0, 3) == 0);
            load_val = 4'($urandom_range(0, 15));
            start    = ($urandom_range(0, 3) == 0);
            dir      = 1'($urandom_range(0, 1));
            stop     = ($urandom_range(0, 7) == 0);
            o_ready  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 59) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end
            tick();
            rst_n = 1'b1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
